scarf_bram_ctrl: RTL and testbench

SCARF_BRAM_CTRL -- requirements
Module: scarf_bram_ctrl

---
 rtl/scarf_pkg.sv | 15 +
 rtl/bram_sp.sv | 29 ++
 rtl/scarf_bram_ctrl.sv | 113 +++++++++++
 tb/tb_scarf_bram_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarf_pkg.sv
// Shared definitions for the SCARF SPI-to-BRAM bridge: FSM state encoding
// and the default bus address of the bridge.
package scarf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_SKIP  = 3'd4
   } state_e;

   localparam logic [6:0] DEFAULT_SLAVE_ID = 7'h01;

endpackage : scarf_pkg

// File: rtl/bram_sp.sv
// Single-port byte-wide RAM, 2^ADDR_W deep, with a registered read port.
// A read issued in the same cycle as a write to that address returns the
// previous contents.
module bram_sp #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // Write port plus one-clock registered read of the addressed word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule : bram_sp

// File: rtl/scarf_bram_ctrl.sv
// SPI-slave to single-port BRAM bridge. The SPI front end hands over one
// byte per data_in_valid strobe; the first byte of a selected transaction
// is the RAM address, later bytes are written (write cycles) or only
// advance the address (read cycles). The RAM itself sits beside this block.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | chip select inactive, waiting for a new transaction
//   ADDR   | chip select active, waiting for the address byte
//   WDATA  | each byte is written at ram_addr, then ram_addr advances
//   RDATA  | each byte advances ram_addr; read_data_out follows the RAM
//   SKIP   | transaction addressed to another slave, ignore until finish
module scarf_bram_ctrl
   import scarf_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ID = DEFAULT_SLAVE_ID,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n_sync,
   input  logic [7:0]        data_in,
   input  logic              data_in_valid,
   input  logic              data_in_finished,
   input  logic [6:0]        slave_id_in,
   input  logic              rnw_in,
   output logic [7:0]        read_data_out,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic              we_q;
   logic [7:0]        rdata_q;
   logic              id_hit;
   logic [ADDR_W-1:0] byte_addr;

   assign id_hit    = (slave_id_in == SLAVE_ID);
   assign byte_addr = ADDR_W'(data_in);

   // Next-state decode; end of chip select wins over everything else.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_ADDR;
         ST_ADDR: begin
            if (data_in_valid) begin
               if (!id_hit) begin
                  state_d = ST_SKIP;
               end else if (rnw_in) begin
                  state_d = ST_RDATA;
               end else begin
                  state_d = ST_WDATA;
               end
            end
         end
         default: state_d = state_q;
      endcase
      if (data_in_finished) begin
         state_d = ST_IDLE;
      end
   end

   // State register and all registered outputs. The write-enable pulse
   // itself triggers the post-write address increment one clock later, so a
   // byte accepted together with the end of chip select still completes.
   // read_data_out is gated by the next state so it is zero in exactly the
   // cycles the FSM is outside RDATA.
   always_ff @(posedge clk) begin
      if (!rst_n_sync) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         we_q    <= 1'b0;
         rdata_q <= (state_d == ST_RDATA) ? ram_rdata : 8'h00;
         if (we_q) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
         case (state_q)
            ST_ADDR: begin
               if (data_in_valid && id_hit) begin
                  addr_q <= byte_addr;
               end
            end
            ST_WDATA: begin
               if (data_in_valid) begin
                  wdata_q <= data_in;
                  we_q    <= 1'b1;
               end
            end
            ST_RDATA: begin
               if (data_in_valid) begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_addr      = addr_q;
   assign ram_wdata     = wdata_q;
   assign ram_we        = we_q;
   assign read_data_out = rdata_q;

endmodule : scarf_bram_ctrl

// File: tb/tb_scarf_bram_ctrl.sv
// Testbench for scarf_bram_ctrl with a bram_sp instance beside it.
module tb_scarf_bram_ctrl;

   logic       clk;
   logic       rst_n_sync;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_finished;
   logic [6:0] slave_id_in;
   logic       rnw_in;
   logic [7:0] read_data_out;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       ram_we;
   logic [7:0] ram_rdata;

   scarf_bram_ctrl #(.SLAVE_ID(7'h01), .ADDR_W(8)) dut (
      .clk              (clk),
      .rst_n_sync       (rst_n_sync),
      .data_in          (data_in),
      .data_in_valid    (data_in_valid),
      .data_in_finished (data_in_finished),
      .slave_id_in      (slave_id_in),
      .rnw_in           (rnw_in),
      .read_data_out    (read_data_out),
      .ram_addr         (ram_addr),
      .ram_wdata        (ram_wdata),
      .ram_we           (ram_we),
      .ram_rdata        (ram_rdata)
   );

   bram_sp #(.ADDR_W(8)) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] slave;
      logic       rnw;
      logic [7:0] addr;
      int         nb;
      logic [7:0] d      [4];
      logic [7:0] exp_rd [4];
      int         exp_we;
   } vec_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   int  checks   = 0;
   int  failures = 0;
   int  we_cnt   = 0;
   bit  mon_en   = 0;
   bit  rd_active = 0;
   wr_t exp_q[$];
   logic [7:0] model_mem [256];
   bit         known     [256];
   vec_t       tbl       [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] s, input logic r, input logic [7:0] a,
                               input int nb, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] e0, input logic [7:0] e1, input int we);
      vec_t v;
      v.slave = s; v.rnw = r; v.addr = a; v.nb = nb;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = 8'h00; v.d[3] = 8'h00;
      v.exp_rd[0] = e0; v.exp_rd[1] = e1; v.exp_rd[2] = 8'h00; v.exp_rd[3] = 8'h00;
      v.exp_we = we;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] b);
      data_in       = b;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
   endtask

   // Expected write: model memory and the scoreboard queue.
   task automatic expect_wr(input logic [7:0] a, input logic [7:0] b);
      wr_t e;
      e.addr = a; e.data = b;
      exp_q.push_back(e);
      model_mem[a] = b;
      known[a]     = 1'b1;
   endtask

   // Every write-enable pulse must match the next expected write; outside
   // an active matching read, read_data_out must be zero.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
               chk("we_unexpected", {24'h0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("we_addr", {24'h0, ram_addr}, {24'h0, e.addr});
               chk("we_data", {24'h0, ram_wdata}, {24'h0, e.data});
            end
         end
         if (!rd_active) begin
            chk("rd_zero", {24'h0, read_data_out}, 32'h0);
         end
      end
   end

   // One complete bus transaction; bytes are spaced 8 clocks apart.
   task automatic run_txn(input vec_t v, input bit use_tbl);
      int         we0;
      bit         hit;
      logic [7:0] a;
      logic [7:0] exp;
      we0 = we_cnt;
      hit = (v.slave == 7'h01);
      slave_id_in      = v.slave;
      rnw_in           = v.rnw;
      data_in_finished = 1'b0;
      if (hit && v.rnw) rd_active = 1'b1;
      repeat (3) tick();
      pulse(v.addr);
      for (int k = 0; k < v.nb; k++) begin
         repeat (7) tick();
         a = v.addr + 8'(k);
         if (v.rnw) begin
            exp = use_tbl ? v.exp_rd[k] : (hit ? model_mem[a] : 8'h00);
            if (use_tbl || !hit || known[a]) begin
               chk("rd_byte", {24'h0, read_data_out}, {24'h0, exp});
            end
            pulse(8'($urandom));
         end else begin
            if (hit) expect_wr(a, v.d[k]);
            pulse(v.d[k]);
         end
      end
      repeat (7) tick();
      data_in_finished = 1'b1;
      repeat (2) tick();
      chk("rd_after_finish", {24'h0, read_data_out}, 32'h0);
      rd_active = 1'b0;
      if (use_tbl) chk("we_count", 32'(we_cnt - we0), 32'(v.exp_we));
      chk("wr_pending", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = 8'h00;
         known[i]     = 1'b0;
      end
      tbl[0] = mk(7'h01, 1'b0, 8'h10, 2, 8'hA5, 8'h5A, 8'h00, 8'h00, 2);
      tbl[1] = mk(7'h01, 1'b1, 8'h10, 2, 8'h00, 8'h00, 8'hA5, 8'h5A, 0);
      tbl[2] = mk(7'h02, 1'b0, 8'h20, 2, 8'h77, 8'h88, 8'h00, 8'h00, 0);
      tbl[3] = mk(7'h02, 1'b1, 8'h10, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      tbl[4] = mk(7'h01, 1'b0, 8'hFF, 2, 8'h11, 8'h22, 8'h00, 8'h00, 2);
      tbl[5] = mk(7'h01, 1'b1, 8'hFF, 2, 8'h00, 8'h00, 8'h11, 8'h22, 0);
      tbl[6] = mk(7'h01, 1'b1, 8'h11, 1, 8'h00, 8'h00, 8'h5A, 8'h00, 0);

      rst_n_sync       = 1'b0;
      data_in          = 8'h00;
      data_in_valid    = 1'b0;
      data_in_finished = 1'b1;
      slave_id_in      = 7'h00;
      rnw_in           = 1'b0;
      repeat (3) tick();
      chk("rst_addr",  {24'h0, ram_addr},      32'h0);
      chk("rst_wdata", {24'h0, ram_wdata},     32'h0);
      chk("rst_we",    {31'h0, ram_we},        32'h0);
      chk("rst_rdata", {24'h0, read_data_out}, 32'h0);
      rst_n_sync = 1'b1;
      mon_en     = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b1);

      // Reset arriving with the second write byte: first byte kept, second dropped.
      slave_id_in = 7'h01; rnw_in = 1'b0; data_in_finished = 1'b0;
      repeat (3) tick();
      pulse(8'h40);
      repeat (7) tick();
      expect_wr(8'h40, 8'h33);
      pulse(8'h33);
      repeat (7) tick();
      rst_n_sync = 1'b0; data_in = 8'h99; data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
      tick();
      chk("rstmid_addr",  {24'h0, ram_addr},      32'h0);
      chk("rstmid_wdata", {24'h0, ram_wdata},     32'h0);
      chk("rstmid_we",    {31'h0, ram_we},        32'h0);
      chk("rstmid_rdata", {24'h0, read_data_out}, 32'h0);
      data_in_finished = 1'b1;
      rst_n_sync = 1'b1;
      repeat (2) tick();
      run_txn(mk(7'h01, 1'b0, 8'h41, 1, 8'h55, 8'h00, 8'h00, 8'h00, 1), 1'b1);
      run_txn(mk(7'h01, 1'b1, 8'h40, 2, 8'h00, 8'h00, 8'h33, 8'h55, 0), 1'b1);

      // Byte accepted together with end of chip select, then an address
      // byte that must not be taken as write data.
      slave_id_in = 7'h01; rnw_in = 1'b0; data_in_finished = 1'b0;
      repeat (3) tick();
      pulse(8'h60);
      repeat (7) tick();
      expect_wr(8'h60, 8'hC3);
      pulse(8'hC3);
      repeat (7) tick();
      expect_wr(8'h61, 8'h3C);
      data_in = 8'h3C; data_in_valid = 1'b1; data_in_finished = 1'b1;
      tick();
      data_in_valid = 1'b0;
      repeat (5) tick();
      chk("fin_addr_inc", {24'h0, ram_addr}, 32'h62);
      data_in_finished = 1'b0;
      repeat (3) tick();
      pulse(8'h70);
      chk("fin_new_addr", {24'h0, ram_addr}, 32'h70);
      repeat (7) tick();
      expect_wr(8'h70, 8'hAB);
      pulse(8'hAB);
      repeat (7) tick();
      data_in_finished = 1'b1;
      repeat (3) tick();
      chk("fin_pending", 32'(exp_q.size()), 32'h0);
      run_txn(mk(7'h01, 1'b1, 8'h60, 2, 8'h00, 8'h00, 8'hC3, 8'h3C, 0), 1'b1);

      // Randomized transactions against the memory model.
      for (int n = 0; n < 40; n++) begin
         v = mk(($urandom_range(0, 3) == 0) ? 7'h02 : 7'h01, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFC, 8'hFF))
                                            : 8'($urandom_range(0, 15)),
                $urandom_range(1, 4), 8'h00, 8'h00, 8'h00, 8'h00, 0);
         for (int k = 0; k < 4; k++) v.d[k] = 8'($urandom);
         run_txn(v, 1'b0);
      end

      chk("final_pending", 32'(exp_q.size()), 32'h0);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_scarf_bram_ctrl
